// File: rtl/gouram_trace_pkg.sv
// rtl/gouram_trace_pkg.sv - shared trace record types for the gouram trace pipeline
//
// Contents:
//   ADDR_WIDTH, DATA_WIDTH : widths of the address and instruction fields
//   timestamp_t            : timestamp sub-record
//   mem_access_t           : start/end timestamps of one memory access phase
//   if_data_t              : IF-stage timing (time_start/time_end, mem_access_req/res)
//   trace_format           : complete IF trace record (addr, instruction, if_data)
package gouram_trace_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef struct packed {
      logic [31:0] cycle;
   } timestamp_t;

   typedef struct packed {
      timestamp_t time_start;
      timestamp_t time_end;
   } mem_access_t;

   typedef struct packed {
      timestamp_t  time_start;
      timestamp_t  time_end;
      mem_access_t mem_access_req;
      mem_access_t mem_access_res;
   } if_data_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] instruction;
      if_data_t              if_data;
   } trace_format;

endpackage

// File: rtl/if_trace_buffer_if.sv
// rtl/if_trace_buffer_if.sv - push/pop handshake bundle of the IF trace buffer
//
// Signals:
//   if_data_valid : one-cycle push strobe from the IF tracker
//   if_data_i     : record to push
//   trace_valid_o : head entry available
//   trace_o       : head entry
//   trace_ready_i : consumer accepts the head when high together with trace_valid_o
// Modports:
//   master : IF tracker / ID-stage consumer side (drives pushes and ready)
//   slave  : the buffer itself
interface if_trace_buffer_if #(
   parameter type trace_format = int
);

   logic        if_data_valid;
   trace_format if_data_i;
   logic        trace_valid_o;
   trace_format trace_o;
   logic        trace_ready_i;

   modport master (
      output if_data_valid,
      output if_data_i,
      output trace_ready_i,
      input  trace_valid_o,
      input  trace_o
   );

   modport slave (
      input  if_data_valid,
      input  if_data_i,
      input  trace_ready_i,
      output trace_valid_o,
      output trace_o
   );

endinterface

// File: rtl/if_trace_buffer.sv
// rtl/if_trace_buffer.sv - first-word-fall-through elastic buffer for IF trace records
//
// Ports:
//   clk          : single clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : if_trace_buffer_if.slave (push strobe/data, head valid/data, ready)
//   flush        : discard all stored records (a same-cycle push is kept)
//   count_o      : current occupancy
//   full_o       : occupancy == DEPTH
//   overflow_o   : sticky, a push was dropped since reset
//   drop_count_o : saturating dropped-push counter, present only with
//                  IF_TRACE_BUFFER_DROP_CNT_EN defined
module if_trace_buffer
   import gouram_trace_pkg::*;
#(
   parameter int  ADDR_WIDTH   = 32,
   parameter int  DATA_WIDTH   = 32,
   parameter int  DEPTH        = 4,
   parameter type trace_format = int
) (
   input  logic                     clk,
   input  logic                     rst,
   if_trace_buffer_if.slave         bus,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
`ifdef IF_TRACE_BUFFER_DROP_CNT_EN
   output logic [15:0]              drop_count_o,
`endif
   output logic                     overflow_o
);

   localparam int PTR_W     = $clog2(DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int DROP_CNT_W = 16;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("if_trace_buffer: DEPTH must be a power of two >= 2");
      end
      if (ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_width
         $error("if_trace_buffer: ADDR_WIDTH and DATA_WIDTH must be positive");
      end
   endgenerate

   trace_format      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;

   logic             push;
   logic             pop;
   logic             full;
   logic             drop;
   logic             accept;
   logic [PTR_W-1:0] wr_idx;

   assign push   = bus.if_data_valid;
   assign full   = (count == CNT_W'(DEPTH));
   assign pop    = (count != '0) && bus.trace_ready_i;
   // A flush empties the buffer, so a push in the flush cycle always fits.
   // At full, a simultaneous pop frees the slot the push needs.
   assign drop   = push && !flush && full && !pop;
   assign accept = push && !drop;
   assign wr_idx = flush ? '0 : wr_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= push ? PTR_W'(1) : '0;
         count  <= push ? CNT_W'(1) : '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            count <= count + 1'b1;
         end else if (!accept && pop) begin
            count <= count - 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Data storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_idx] <= bus.if_data_i;
      end
   end

`ifdef IF_TRACE_BUFFER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_count <= '0;
      end else if (drop && drop_count != {DROP_CNT_W{1'b1}}) begin
         drop_count <= drop_count + 1'b1;
      end
   end

   assign drop_count_o = drop_count;
`endif

   assign bus.trace_valid_o = (count != '0);
   // Masked while empty so the head reads 0 out of reset despite unreset storage.
   assign bus.trace_o       = (count != '0) ? mem[rd_ptr] : '0;
   assign count_o           = count;
   assign full_o            = full;
   assign overflow_o        = overflow;

endmodule
